// File: rtl/vga_scan.sv
// vga_scan: VGA raster timing generator.
// hcount/vcount free-run over the full line/frame. Colour, sync and frame_tick
// are produced by one register stage, so they line up with each other one clk
// after the (curr_x, curr_y) they belong to.
// Optional feature: define VGA_SCAN_BORDER_EN to force white on the outermost
// visible row/column (timing is unaffected).
module vga_scan #(
  parameter int unsigned HVIS      = 1440,
  parameter int unsigned HFP       = 80,
  parameter int unsigned HSW       = 152,
  parameter int unsigned HBP       = 232,
  parameter int unsigned VVIS      = 900,
  parameter int unsigned VFP       = 1,
  parameter int unsigned VSW       = 3,
  parameter int unsigned VBP       = 28,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] curr_x,
  output logic [10:0] curr_y,
  input  logic [3:0]  draw_r,
  input  logic [3:0]  draw_g,
  input  logic [3:0]  draw_b,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  // Counter thresholds, all in the 11-bit counter domain.
  localparam logic [10:0] H_VIS        = 11'(HVIS);
  localparam logic [10:0] H_VIS_LAST   = 11'(HVIS - 1);
  localparam logic [10:0] H_SYNC_START = 11'(HVIS + HFP);
  localparam logic [10:0] H_SYNC_END   = 11'(HVIS + HFP + HSW);
  localparam logic [10:0] H_LAST       = 11'(HVIS + HFP + HSW + HBP - 1);
  localparam logic [10:0] V_VIS        = 11'(VVIS);
  localparam logic [10:0] V_VIS_LAST   = 11'(VVIS - 1);
  localparam logic [10:0] V_SYNC_START = 11'(VVIS + VFP);
  localparam logic [10:0] V_SYNC_END   = 11'(VVIS + VFP + VSW);
  localparam logic [10:0] V_LAST       = 11'(VVIS + VFP + VSW + VBP - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic [3:0]  pix_r_q, pix_r_d;
  logic [3:0]  pix_g_q, pix_g_d;
  logic [3:0]  pix_b_q, pix_b_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_tick_q, frame_tick_d;
  logic        h_wrap_s;
  logic        visible_s;
`ifdef VGA_SCAN_BORDER_EN
  logic        border_s;
`endif

  // Next raster position: h wraps every line, v steps only on the h wrap.
  always_comb begin
    h_wrap_s = (hcount_q == H_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (h_wrap_s) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d = 11'd0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end else begin
      hcount_d = hcount_q + 11'd1;
    end
  end

  // Output stage inputs: blank colour outside the visible area, decode syncs and the frame tick.
  always_comb begin
    visible_s    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    pix_r_d      = 4'h0;
    pix_g_d      = 4'h0;
    pix_b_d      = 4'h0;
    hsync_d      = ~HSYNC_POL;
    vsync_d      = ~VSYNC_POL;
    frame_tick_d = 1'b0;

    // A mux (not an AND) so blanked pixels are 0 even if draw_* is unknown.
    if (visible_s) begin
      pix_r_d = draw_r;
      pix_g_d = draw_g;
      pix_b_d = draw_b;
    end else begin
      pix_r_d = 4'h0;
      pix_g_d = 4'h0;
      pix_b_d = 4'h0;
    end

`ifdef VGA_SCAN_BORDER_EN
    border_s = visible_s &&
               ((hcount_q == 11'd0) || (hcount_q == H_VIS_LAST) ||
                (vcount_q == 11'd0) || (vcount_q == V_VIS_LAST));
    if (border_s) begin
      pix_r_d = 4'hF;
      pix_g_d = 4'hF;
      pix_b_d = 4'hF;
    end else begin
      pix_r_d = pix_r_d;
      pix_g_d = pix_g_d;
      pix_b_d = pix_b_d;
    end
`endif

    if ((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END)) begin
      hsync_d = HSYNC_POL;
    end else begin
      hsync_d = ~HSYNC_POL;
    end

    if ((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END)) begin
      vsync_d = VSYNC_POL;
    end else begin
      vsync_d = ~VSYNC_POL;
    end

    if ((hcount_q == 11'd0) && (vcount_q == V_VIS)) begin
      frame_tick_d = 1'b1;
    end else begin
      frame_tick_d = 1'b0;
    end
  end

  // State and output registers; reset is asynchronous so outputs idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q     <= 11'd0;
      vcount_q     <= 11'd0;
      pix_r_q      <= 4'h0;
      pix_g_q      <= 4'h0;
      pix_b_q      <= 4'h0;
      hsync_q      <= ~HSYNC_POL;
      vsync_q      <= ~VSYNC_POL;
      frame_tick_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Position comes straight from the counters: no path from draw_* to curr_x/curr_y.
  assign curr_x     = hcount_q;
  assign curr_y     = vcount_q;
  assign pix_r      = pix_r_q;
  assign pix_g      = pix_g_q;
  assign pix_b      = pix_b_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: scoreboard bench for vga_scan.
// Horizontal timing uses the default 1904-clk line; the frame is shortened to
// 11 lines (VVIS=6, VFP=1, VSW=3, VBP=1) so two full frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_scan;

  localparam int HVIS   = 1440;
  localparam int HFP    = 80;
  localparam int HSW    = 152;
  localparam int HBP    = 232;
  localparam int VVIS   = 6;
  localparam int VFP    = 1;
  localparam int VSW    = 3;
  localparam int VBP    = 1;
  localparam int HTOTAL = 1904;
  localparam int VTOTAL = 11;
  localparam int FRAME  = 20944;

  logic        clk;
  logic        rst;
  logic [10:0] curr_x, curr_y;
  logic [3:0]  draw_r, draw_g, draw_b;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic        hsync, vsync, frame_tick;

  vga_scan #(
    .HVIS(HVIS), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .curr_x(curr_x), .curr_y(curr_y),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        tk;
  } obs_t;

  obs_t sb_q[$];
  obs_t mon_exp;
  obs_t mon_act;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Run-length trackers (monitor only).
  int hs_since_fall, hs_low_run, vs_hi_run, tick_since, tick_count;
  bit hs_fall_seen, vs_rise_seen, tick_seen, prev_hs, prev_vs;

  // Model position and frame index (stimulus only).
  int mx, my, fidx;

  function automatic obs_t sample_dut();
    obs_t o;
    o.x  = curr_x;
    o.y  = curr_y;
    o.r  = pix_r;
    o.g  = pix_g;
    o.b  = pix_b;
    o.hs = hsync;
    o.vs = vsync;
    o.tk = frame_tick;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b tk=%b, required x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b tk=%b",
               name, $time, act.x, act.y, act.r, act.g, act.b, act.hs, act.vs, act.tk,
               req.x, req.y, req.r, req.g, req.b, req.hs, req.vs, req.tk);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, req);
    end
  endtask

  task automatic check_reset_state(input string name);
    obs_t r;
    r = '{x: 11'd0, y: 11'd0, r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b0, tk: 1'b0};
    check_obs(name, sample_dut(), r);
  endtask

  // One stimulus cycle at a negedge: drive draw_* for the model position,
  // queue the registered response expected after the next posedge, advance.
  task automatic step();
    logic [3:0] dr, dg, db;
    obs_t e;
    bit vis;
    if (fidx == 0) begin
      dr = 4'hA; dg = 4'hA; db = 4'hA;
    end else if (fidx == 1) begin
      dr = 4'h0; dg = 4'h0; db = 4'h0;
    end else begin
      dr = 4'h3; dg = 4'h6; db = 4'hC;
    end
    draw_r = dr; draw_g = dg; draw_b = db;

    vis  = (mx < HVIS) && (my < VVIS);
    e.r  = vis ? dr : 4'h0;
    e.g  = vis ? dg : 4'h0;
    e.b  = vis ? db : 4'h0;
`ifdef VGA_SCAN_BORDER_EN
    if (vis && (mx == 0 || mx == HVIS - 1 || my == 0 || my == VVIS - 1)) begin
      e.r = 4'hF; e.g = 4'hF; e.b = 4'hF;
    end
`endif
    e.hs = !((mx >= 1520) && (mx < 1672));
    e.vs = (my >= 7) && (my < 10);
    e.tk = (mx == 0) && (my == 6);

    if (mx == HTOTAL - 1) begin
      mx = 0;
      if (my == VTOTAL - 1) begin
        my = 0;
        fidx++;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    e.x = 11'(mx);
    e.y = 11'(my);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: just after each active edge pop one expectation and compare;
  // also measure sync widths, line period and frame-tick spacing from the outputs.
  always @(posedge clk) begin
    #1;
    if (mon_en && sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_act = sample_dut();
      check_obs("scoreboard", mon_act, mon_exp);

      hs_since_fall++;
      if (prev_hs && !hsync) begin
        if (hs_fall_seen) check_int("line_period", hs_since_fall, HTOTAL);
        hs_fall_seen  = 1'b1;
        hs_since_fall = 0;
        hs_low_run    = 0;
      end
      if (!hsync) hs_low_run++;
      if (!prev_hs && hsync && hs_fall_seen) check_int("hsync_low_clks", hs_low_run, HSW);

      if (!prev_vs && vsync) begin
        vs_rise_seen = 1'b1;
        vs_hi_run    = 0;
      end
      if (vsync) vs_hi_run++;
      if (prev_vs && !vsync && vs_rise_seen) check_int("vsync_high_clks", vs_hi_run, VSW * HTOTAL);

      tick_since++;
      if (frame_tick) begin
        if (tick_seen) check_int("frame_tick_gap", tick_since, FRAME);
        tick_seen  = 1'b1;
        tick_since = 0;
        tick_count++;
      end

      prev_hs = hsync;
      prev_vs = vsync;
    end else if (!mon_en) begin
      hs_since_fall = 0; hs_low_run = 0; vs_hi_run = 0; tick_since = 0;
      hs_fall_seen = 1'b0; vs_rise_seen = 1'b0; tick_seen = 1'b0;
      prev_hs = 1'b1; prev_vs = 1'b0;
    end
  end

  // Watchdog: the run is clock-bounded, this only catches a stuck simulation.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    tick_count = 0;
    rst = 1'b0;
    draw_r = 4'hF; draw_g = 4'hF; draw_b = 4'hF;
    #1 rst = 1'b1;
    #1 check_reset_state("reset_async_start");
    repeat (5) begin
      @(negedge clk);
      check_reset_state("reset_hold");
    end

    // Release and run two full frames plus part of a third.
    rst = 1'b0;
    mx = 0; my = 0; fidx = 0;
    mon_en = 1'b1;
    while (!(fidx == 2 && my == 4 && mx == 700)) step();

    // Mid-frame asynchronous reset, between edges.
    check_int("pre_reset_x", int'(curr_x), 700);
    check_int("pre_reset_y", int'(curr_y), 4);
    check_int("queue_drained_1", sb_q.size(), 0);
    check_int("ticks_two_frames", tick_count, 2);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("reset_async_midframe");
    @(negedge clk);
    check_reset_state("reset_after_edge");

    // Counting restarts from (0,0).
    rst = 1'b0;
    mx = 0; my = 0; fidx = 0;
    mon_en = 1'b1;
    repeat (2 * HTOTAL + 10) step();
    @(negedge clk);
    check_int("queue_drained_2", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
